// File: rtl/poly_deriv_seq.sv
// Polynomial term derivative sequencer: buffers one frame of (coefficient,
// exponent) terms, then emits d/dx of each nonzero term in acceptance order.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   LOAD    | accepting input terms into the frame buffer
//   COMPUTE | examining buffer[rd_idx]; skips zero terms, registers results
//   EMIT    | presenting a derivative term until the consumer takes it
//   DONE    | frame had no nonzero terms; presenting a single (0,0,last)
module poly_deriv_seq #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_base,
  input  logic [3:0] in_root,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_base,
  output logic [7:0] out_root,
  output logic       out_last,
  output logic       busy
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {LOAD, COMPUTE, EMIT, DONE} state_t;

  state_t        state, next_state;
  logic [3:0]    base_buf [DEPTH];
  logic [3:0]    root_buf [DEPTH];
  logic [IW-1:0] wr_idx, rd_idx, last_idx;
  logic          cur_zero, more_nz, frame_end;
  logic [3:0]    cur_base, cur_root;

  assign cur_base  = base_buf[rd_idx];
  assign cur_root  = root_buf[rd_idx];
  assign cur_zero  = (cur_base == 4'd0) || (cur_root == 4'd0);
  // A DEPTH-th term closes the frame regardless of its in_last flag.
  assign frame_end = in_last || (wr_idx == IW'(DEPTH - 1));

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT) || (state == DONE);
  assign busy      = (state != LOAD);

  // Look ahead for any nonzero term after rd_idx within this frame.
  always_comb begin
    more_nz = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if ((IW'(j) > rd_idx) && (IW'(j) <= last_idx) &&
          (base_buf[j] != 4'd0) && (root_buf[j] != 4'd0))
        more_nz = 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (in_valid && frame_end) next_state = COMPUTE;
      COMPUTE: begin
        if (!cur_zero)                next_state = EMIT;
        else if (rd_idx == last_idx)  next_state = DONE;
      end
      EMIT:    if (out_ready) next_state = out_last ? LOAD : COMPUTE;
      DONE:    if (out_ready) next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  // Frame buffer write; contents need no reset since indices gate all reads.
  always_ff @(posedge clk) begin
    if (!reset && state == LOAD && in_valid) begin
      base_buf[wr_idx] <= in_base;
      root_buf[wr_idx] <= in_root;
    end
  end

  // State register, indices and registered output term.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      wr_idx   <= '0;
      rd_idx   <= '0;
      last_idx <= '0;
      out_base <= 8'd0;
      out_root <= 8'd0;
      out_last <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        LOAD: begin
          if (in_valid) begin
            last_idx <= wr_idx;
            wr_idx   <= wr_idx + 1'b1;
            rd_idx   <= '0;
          end
        end
        COMPUTE: begin
          if (!cur_zero) begin
            out_base <= 8'(cur_base) * 8'(cur_root);
            out_root <= 8'(cur_root - 4'd1);
            out_last <= !more_nz;
          end else if (rd_idx == last_idx) begin
            out_base <= 8'd0;
            out_root <= 8'd0;
            out_last <= 1'b1;
          end else begin
            rd_idx <= rd_idx + 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              wr_idx <= '0;
              rd_idx <= '0;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            wr_idx <= '0;
            rd_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_deriv_seq.sv
// Directed bench for poly_deriv_seq: table of frames with expected derivative
// terms and output wait counts, plus hand sequences for stall, reset and
// ignored input during busy states.
module tb_poly_deriv_seq;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, in_last;
  logic [3:0] in_base, in_root;
  logic       out_valid, out_ready, out_last, busy;
  logic [7:0] out_base, out_root;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] r;
    logic       l;
  } term_t;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] r;
    logic       l;
    logic [7:0] w;
  } exp_t;

  term_t terms[$];
  exp_t  exps[$];
  int    fr_nt[$];
  int    fr_ne[$];

  poly_deriv_seq #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_root(in_root), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_base(out_base),
    .out_root(out_root), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Hard stop in case something upstream hangs.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_t(input logic [3:0] b, input logic [3:0] r, input logic l);
    term_t t;
    t.b = b; t.r = r; t.l = l;
    terms.push_back(t);
  endtask

  task automatic add_e(input logic [7:0] b, input logic [7:0] r, input logic l, input logic [7:0] w);
    exp_t e;
    e.b = b; e.r = r; e.l = l; e.w = w;
    exps.push_back(e);
  endtask

  // Present one term and hold it until accepted (in_valid stays high after).
  task automatic send_term(input logic [3:0] b, input logic [3:0] r, input logic l);
    int k = 0;
    @(negedge clk);
    in_valid = 1'b1; in_base = b; in_root = r; in_last = l;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("send accepted", 32'(in_ready), 32'd1);
    @(posedge clk);
  endtask

  // Wait for an output term, compare it and its wait count, then pass the edge.
  task automatic expect_out(input logic [7:0] eb, input logic [7:0] er, input logic el,
                            input int ew, input string tag);
    int k = 0;
    @(negedge clk);
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " wait"}, 32'(k), 32'(ew));
    chk({tag, " base"}, 32'(out_base), 32'(eb));
    chk({tag, " root"}, 32'(out_root), 32'(er));
    chk({tag, " last"}, 32'(out_last), 32'(el));
    @(posedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " out_valid seen"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  task automatic drop_input(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " in_ready after load"}, 32'(in_ready), 32'd0);
    chk({tag, " busy after load"}, 32'(busy), 32'd1);
    chk({tag, " out_valid in compute"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int ti, ei, cnt;
    reset = 1'b1; in_valid = 1'b0; in_base = '0; in_root = '0; in_last = 1'b0;
    out_ready = 1'b1;

    // Frame table: terms (base, root, last) and expected (base, root, last, wait).
    add_t(3, 2, 0); add_t(5, 1, 0); add_t(7, 0, 1);
    add_e(6, 1, 0, 0); add_e(5, 0, 1, 1);
    fr_nt.push_back(3); fr_ne.push_back(2);
    add_t(0, 3, 0); add_t(4, 0, 1);
    add_e(0, 0, 1, 1);
    fr_nt.push_back(2); fr_ne.push_back(1);
    add_t(15, 15, 0); add_t(1, 1, 0); add_t(2, 2, 0); add_t(3, 3, 0);
    add_e(225, 14, 0, 0); add_e(1, 0, 0, 1); add_e(4, 1, 0, 1); add_e(9, 2, 1, 1);
    fr_nt.push_back(4); fr_ne.push_back(4);
    add_t(0, 0, 0); add_t(2, 3, 0); add_t(0, 5, 0); add_t(1, 2, 1);
    add_e(6, 2, 0, 1); add_e(2, 1, 1, 2);
    fr_nt.push_back(4); fr_ne.push_back(2);
    add_t(9, 1, 1);
    add_e(9, 0, 1, 0);
    fr_nt.push_back(1); fr_ne.push_back(1);
    add_t(4, 2, 0); add_t(0, 0, 1);
    add_e(8, 1, 1, 0);
    fr_nt.push_back(2); fr_ne.push_back(1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_base", 32'(out_base), 32'd0);
    chk("reset out_root", 32'(out_root), 32'd0);
    chk("reset out_last", 32'(out_last), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    ti = 0; ei = 0;
    for (int f = 0; f < fr_nt.size(); f++) begin
      for (int i = 0; i < fr_nt[f]; i++)
        send_term(terms[ti + i].b, terms[ti + i].r, terms[ti + i].l);
      drop_input($sformatf("frame%0d", f));
      for (int i = 0; i < fr_ne[f]; i++)
        expect_out(exps[ei + i].b, exps[ei + i].r, exps[ei + i].l, int'(exps[ei + i].w),
                   $sformatf("frame%0d out%0d", f, i));
      check_idle($sformatf("frame%0d", f));
      ti += fr_nt[f];
      ei += fr_ne[f];
    end

    // Consumer stalls for 5 cycles on the first output.
    out_ready = 1'b0;
    send_term(3, 2, 0); send_term(5, 1, 0); send_term(7, 0, 1);
    drop_input("stall");
    wait_valid("stall");
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("stall hold cycle%0d", c),
          {14'd0, out_valid, busy, out_base, out_root, out_last, in_ready},
          {14'd0, 1'b1, 1'b1, 8'd6, 8'd1, 1'b0, 1'b0});
    end
    out_ready = 1'b1;
    @(posedge clk);
    expect_out(5, 0, 1, 1, "stall second");
    check_idle("stall");

    // Reset while an output is pending, coinciding with a consumer handshake.
    out_ready = 1'b0;
    send_term(3, 2, 0); send_term(5, 1, 0); send_term(7, 0, 1);
    drop_input("rst");
    wait_valid("rst");
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out_base", 32'(out_base), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    send_term(2, 3, 1);
    drop_input("rst fresh");
    expect_out(6, 2, 1, 0, "rst fresh");
    check_idle("rst fresh");

    // in_valid kept high with a nonzero term during COMPUTE and EMIT.
    send_term(3, 2, 0); send_term(5, 1, 0); send_term(7, 0, 1);
    @(negedge clk);
    in_base = 4'd1; in_root = 4'd1; in_last = 1'b1;
    chk("busy-in in_ready", 32'(in_ready), 32'd0);
    expect_out(6, 1, 0, 0, "busy-in out0");
    @(negedge clk);
    chk("busy-in in_ready compute", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    expect_out(5, 0, 1, 0, "busy-in out1");
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("busy-in extra outputs", 32'(cnt), 32'd0);
    chk("busy-in in_ready end", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_deriv_seq.md
POLY_DERIV_SEQ -- requirements
Module: poly_deriv_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the maximum number of polynomial terms buffered per frame (legal range 2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: an input term is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a term this cycle.
REQ-006 SHALL have port in_base, input, 4 bits: the term coefficient (unsigned).
REQ-007 SHALL have port in_root, input, 4 bits: the term exponent (unsigned).
REQ-008 SHALL have port in_last, input, 1 bit: the final term of the frame.
REQ-009 SHALL have port out_valid, output, 1 bit: a derivative term is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the output term.
REQ-011 SHALL have port out_base, output, 8 bits: the derivative coefficient.
REQ-012 SHALL have port out_root, output, 8 bits: the derivative exponent.
REQ-013 SHALL have port out_last, output, 1 bit: the final output term of the frame.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except LOAD.

Function
REQ-015 SHALL implement states LOAD, COMPUTE, EMIT and DONE; a handshake completes on any cycle where both valid and ready are high.
REQ-016 In LOAD, SHALL drive in_ready=1 and write each accepted term into buffer[wr_idx], then increment wr_idx.
REQ-017 SHALL move LOAD->COMPUTE on the cycle that accepts a term with in_last=1, or that accepts the DEPTH-th term; a DEPTH-th term is treated as last whatever its in_last value.
REQ-018 SHALL drive in_ready=0 in COMPUTE, EMIT and DONE.
REQ-019 COMPUTE SHALL process one buffered term per cycle, in acceptance order, starting at rd_idx=0.
REQ-020 A term whose base==0 or root==0 is a zero term; COMPUTE SHALL skip it (rd_idx+1, no output) and SHALL remain in COMPUTE.
REQ-021 For a nonzero term, COMPUTE SHALL register out_base = base*root (8-bit product, no truncation, maximum 225) and out_root = root-1 (zero-extended to 8 bits), then enter EMIT.
REQ-022 SHALL set out_last=1 when no nonzero term exists at a buffer index above rd_idx within the frame.
REQ-023 In EMIT, SHALL assert out_valid and hold out_base, out_root and out_last stable until out_ready is high.
REQ-024 On the EMIT handshake: if out_last=1, SHALL go to LOAD with wr_idx=rd_idx=0; otherwise SHALL increment rd_idx and return to COMPUTE.
REQ-025 If COMPUTE exhausts the frame without emitting any term (all terms zero), SHALL enter DONE.
REQ-026 DONE SHALL present out_base=0, out_root=0, out_last=1 with out_valid=1, and SHALL go to LOAD on its handshake.
REQ-027 Latency SHALL be: a first nonzero term at index k is presented k+1 cycles after COMPUTE entry; with out_ready held high, each output follows the previous handshake by 1 + (number of skipped zero terms) cycles.
REQ-028 The next frame's first term SHALL be accepted no earlier than the cycle after the final output handshake.
REQ-029 out_valid SHALL be 0 in LOAD and COMPUTE.
REQ-030 in_valid while in_ready=0 SHALL be ignored and SHALL NOT be buffered.

Reset
REQ-031 When reset is high at a clock edge, the state SHALL become LOAD and wr_idx and rd_idx SHALL become 0, in any state and mid-frame; the partial frame is discarded.
REQ-032 After reset, outputs SHALL be out_valid=0, out_base=0, out_root=0, out_last=0, busy=0 and in_ready=1.
REQ-033 reset SHALL take priority over a simultaneous handshake on either port.

Verification
REQ-034 Bench SHALL cover: frame (3,2),(5,1),(7,0,last) with out_ready=1 -> outputs (6,1,last=0) then (5,0,last=1); (7,0) produces no output.
REQ-035 Bench SHALL cover: frame (0,3),(4,0,last) -> a single DONE output (0,0,last=1), then in_ready=1 the following cycle.
REQ-036 Bench SHALL cover: DEPTH=4, four terms (15,15),(1,1),(2,2),(3,3) with in_last=0 -> LOAD->COMPUTE after the 4th term; outputs (225,14),(1,0),(4,1),(9,2,last=1).
REQ-037 Bench SHALL cover: out_ready low for 5 cycles during EMIT of (6,1) -> out_valid=1 with the data held stable for all 5 cycles, and exactly one handshake.
REQ-038 Bench SHALL cover: reset asserted in EMIT mid-frame -> the next cycle shows out_valid=0, in_ready=1, busy=0, and a fresh frame (2,3,last) yields (6,2,last=1).
REQ-039 Bench SHALL cover: in_valid=1 throughout COMPUTE and EMIT -> no extra term is buffered, and the frame's output count is unchanged.
